// File: rtl/booth_mult_32.sv
// Sequential 32-bit signed radix-2 Booth multiplier.
// One Booth iteration per cycle through a 32-bit carry-lookahead adder built
// from four chained 8-bit CLA blocks plus a separate sign bit; 33-cycle latency.

// 8-bit carry-lookahead adder block.
module cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       t;
  logic       pp;

  // Each carry is a flat generate/propagate sum of products, not a ripple.
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    c  = '0;
    t  = 1'b0;
    pp = 1'b0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      t  = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        t  = t | (pp & g[j]);
        pp = pp & p[j];
      end
      t = t | (pp & cin);
      c[i+1] = t;
    end
    sum  = p ^ c[7:0];
    cout = c[8];
  end

endmodule

// 32-bit adder: four 8-bit CLA blocks with carries chained block to block.
module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  localparam int unsigned NBLK = 4;

  logic [NBLK:0] carry;

  assign carry[0] = cin;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    cla8 u_cla8 (
      .a   (a[8*k +: 8]),
      .b   (b[8*k +: 8]),
      .cin (carry[k]),
      .sum (sum[8*k +: 8]),
      .cout(carry[k+1])
    );
  end

  assign cout = carry[NBLK];

endmodule

// Top: Booth control FSM, product register and result capture.
module booth_mult_32 #(
  parameter int unsigned ITER = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  localparam int unsigned W  = 32;
  localparam int unsigned AW = W + 1;
  localparam int unsigned PW = 2 * W + 2;
  localparam int unsigned CW = $clog2(ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            load;
  logic            iter;
  logic            last;

  logic [W-1:0]    mcand;
  logic [PW-1:0]   prod;
  logic [CW-1:0]   cnt;

  logic [1:0]      booth;
  logic            sub;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   mx;
  logic [W-1:0]    sum_lo;
  logic            cout31;
  logic [AW-1:0]   sum33;
  logic [AW-1:0]   acc_nxt;
  logic [PW-1:0]   prod_shift;
  logic            ovf;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; start is only honoured outside BUSY.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ctrl_MULT) state_nxt = S_BUSY;
      S_BUSY:  if (cnt == CW'(ITER - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = ctrl_MULT ? S_BUSY : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control decode from the state register.
  always_comb begin
    load           = 1'b0;
    iter           = 1'b0;
    last           = 1'b0;
    data_resultRDY = 1'b0;
    case (state)
      S_IDLE: load = ctrl_MULT;
      S_BUSY: begin
        iter = 1'b1;
        last = (cnt == CW'(ITER - 1));
      end
      S_DONE: begin
        load           = ctrl_MULT;
        data_resultRDY = 1'b1;
      end
      default: ;
    endcase
  end

  // One Booth step: conditional add/subtract of sext(M), then arithmetic shift.
  always_comb begin
    booth      = prod[1:0];
    sub        = (booth == 2'b10);
    acc        = prod[PW-1:W+1];
    mx         = {mcand[W-1], mcand} ^ {AW{sub}};
    sum33      = {acc[W] ^ mx[W] ^ cout31, sum_lo};
    acc_nxt    = (booth[1] ^ booth[0]) ? sum33 : acc;
    prod_shift = {acc_nxt[W], acc_nxt, prod[W:1]};
    ovf        = (prod_shift[PW-1:W+1] != {AW{prod_shift[W]}});
  end

  add32 u_add32 (
    .a   (acc[W-1:0]),
    .b   (mx[W-1:0]),
    .cin (sub),
    .sum (sum_lo),
    .cout(cout31)
  );

  // Datapath registers and result capture on the final iteration.
  always_ff @(posedge clock) begin
    if (reset) begin
      mcand          <= '0;
      prod           <= '0;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (load) begin
      mcand <= data_operandA;
      prod  <= {{AW{1'b0}}, data_operandB, 1'b0};
      cnt   <= '0;
    end else if (iter) begin
      prod <= prod_shift;
      cnt  <= cnt + CW'(1);
      if (last) begin
        data_result    <= prod_shift[W:1];
        data_exception <= ovf;
      end
    end
  end

endmodule
